// File: rtl/textmem_wb_if.sv
// Bus bundle for textmem_wb: pipelined Wishbone video (read-only) and CPU ports.
interface textmem_wb_if;
  logic        v_cyc_i;
  logic        v_stb_i;
  logic [31:0] v_adr_i;
  logic [31:0] v_dat_o;
  logic        v_ack_o;
  logic        c_cyc_i;
  logic        c_stb_i;
  logic        c_we_i;
  logic [3:0]  c_sel_i;
  logic [31:0] c_adr_i;
  logic [31:0] c_dat_i;
  logic [31:0] c_dat_o;
  logic        c_ack_o;
  logic        c_stall_o;

  modport slave (
    input  v_cyc_i, v_stb_i, v_adr_i,
    output v_dat_o, v_ack_o,
    input  c_cyc_i, c_stb_i, c_we_i, c_sel_i, c_adr_i, c_dat_i,
    output c_dat_o, c_ack_o, c_stall_o
  );

  modport master (
    output v_cyc_i, v_stb_i, v_adr_i,
    input  v_dat_o, v_ack_o,
    output c_cyc_i, c_stb_i, c_we_i, c_sel_i, c_adr_i, c_dat_i,
    input  c_dat_o, c_ack_o, c_stall_o
  );
endinterface

// File: rtl/textmem_wb.sv
// textmem_wb: text/attribute buffer RAM behind two pipelined Wishbone slaves.
// Video port never stalls (1-cycle latency); CPU port is stalled whenever the
// video port or the clear engine owns the single RAM port.
// Optional macro TEXTMEM_CLEAR_EN: after reset, fill every word with FILL.
module textmem_wb #(
  parameter int unsigned AWIDTH = 11,
  parameter logic [31:0] FILL   = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  textmem_wb_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [31:0]       mem_q [0:DEPTH-1];
  logic [31:0]       v_dat_q, c_dat_q;
  logic              v_ack_q, c_ack_q;
  logic [AWIDTH-1:0] v_idx, c_idx, rd_idx, clr_ptr;
  logic [31:0]       rd_word;
  logic              v_req, c_req, v_acc, c_acc, c_wr, c_rd, stall;
  logic              clearing, clr_we;
  logic              unused_bits;

  assign v_idx = bus.v_adr_i[AWIDTH+1:2];
  assign c_idx = bus.c_adr_i[AWIDTH+1:2];
  assign unused_bits = ^{bus.v_adr_i[31:AWIDTH+2], bus.v_adr_i[1:0],
                         bus.c_adr_i[31:AWIDTH+2], bus.c_adr_i[1:0]};

`ifdef TEXTMEM_CLEAR_EN
  typedef enum logic {S_RUN, S_CLEAR} state_t;
  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;

  // Clear FSM state and pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Walk the pointer once over the RAM; it parks at all-ones rather than wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      if (ptr_q == '1) state_d = S_RUN;
      else             ptr_d   = ptr_q + 1'b1;
    end
  end

  assign clearing = (state_q == S_CLEAR);
  assign clr_we   = clearing & ~rst_i;
  assign clr_ptr  = ptr_q;
  assign stall    = v_req | clearing | rst_i;
`else
  assign clearing = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_ptr  = '0;
  assign stall    = v_req;
`endif

  assign v_req = bus.v_cyc_i & bus.v_stb_i;
  assign c_req = bus.c_cyc_i & bus.c_stb_i;
  assign v_acc = v_req & ~rst_i;
  assign c_acc = c_req & ~stall & ~rst_i;
  assign c_wr  = c_acc & bus.c_we_i;
  assign c_rd  = c_acc & ~bus.c_we_i;

  // One read address into the RAM; the CPU only gets it when video is idle.
  assign rd_idx  = v_acc ? v_idx : c_idx;
  assign rd_word = mem_q[rd_idx];

  // RAM write port: clear engine first, then accepted CPU byte writes.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_ptr] <= FILL;
    end else if (c_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.c_sel_i[b]) mem_q[c_idx][8*b +: 8] <= bus.c_dat_i[8*b +: 8];
      end
    end
  end

  // Ack and read-data registers; during clear video gets FILL without touching the RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_ack_q <= 1'b0;
      c_ack_q <= 1'b0;
      v_dat_q <= '0;
      c_dat_q <= '0;
    end else begin
      v_ack_q <= v_acc;
      c_ack_q <= c_acc;
      if (v_acc) v_dat_q <= clearing ? FILL : rd_word;
      if (c_rd)  c_dat_q <= rd_word;
    end
  end

  // Acks are dropped when the master abandons the cycle or reset hits mid-flight.
  assign bus.v_ack_o   = v_ack_q & bus.v_cyc_i & ~rst_i;
  assign bus.c_ack_o   = c_ack_q & bus.c_cyc_i & ~rst_i;
  assign bus.v_dat_o   = v_dat_q;
  assign bus.c_dat_o   = c_dat_q;
  assign bus.c_stall_o = stall;

endmodule

// File: tb/tb_textmem_wb.sv
// Self-checking bench for textmem_wb: directed steps, per-port expectation
// queues filled at request time and drained in the ack cycle.
module tb_textmem_wb;

  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef TEXTMEM_CLEAR_EN
  localparam logic [31:0] FILL_W = 32'h0720_0720;
  localparam bit          CLR_EN = 1'b1;
`else
  localparam logic [31:0] FILL_W = 32'h0000_0000;
  localparam bit          CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  textmem_wb_if bus ();

  textmem_wb #(.AWIDTH(AW), .FILL(FILL_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] model   [0:DEPTH-1];
  bit          mvalid  [0:DEPTH-1];
  logic [32:0] vq[$];
  logic [32:0] cq[$];
  logic [32:0] c_last;
  int unsigned clr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 after inputs are set; checks this cycle, then advances one edge.
  task automatic tick();
    logic        vreq, creq, stall_e, vack_e, cack_e;
    logic [32:0] e;
    int unsigned vi, ci;
    #1;
    vreq    = bus.v_cyc_i & bus.v_stb_i;
    creq    = bus.c_cyc_i & bus.c_stb_i;
    stall_e = vreq | (CLR_EN & rst) | (clr_cnt != 0);
    vack_e  = (vq.size() > 0) && bus.v_cyc_i && !rst;
    cack_e  = (cq.size() > 0) && bus.c_cyc_i && !rst;
    chk("v_ack", {31'b0, bus.v_ack_o}, {31'b0, vack_e});
    if (vack_e) begin
      e = vq[0];
      if (e[32]) chk("v_dat", bus.v_dat_o, e[31:0]);
    end
    chk("c_ack", {31'b0, bus.c_ack_o}, {31'b0, cack_e});
    if (cack_e) begin
      e = cq[0];
      if (e[32]) chk("c_dat", bus.c_dat_o, e[31:0]);
    end
    chk("c_stall", {31'b0, bus.c_stall_o}, {31'b0, stall_e});
    vq.delete();
    cq.delete();
    if (!rst) begin
      vi = int'(bus.v_adr_i[AW+1:2]);
      ci = int'(bus.c_adr_i[AW+1:2]);
      if (vreq) begin
        if (clr_cnt != 0) vq.push_back({1'b1, FILL_W});
        else              vq.push_back({mvalid[vi], model[vi]});
      end
      if (creq && !stall_e) begin
        if (bus.c_we_i) begin
          cq.push_back(c_last);
          for (int b = 0; b < 4; b++)
            if (bus.c_sel_i[b]) model[ci][8*b +: 8] = bus.c_dat_i[8*b +: 8];
          if (bus.c_sel_i != 4'hf) mvalid[ci] = mvalid[ci];
          else                     mvalid[ci] = 1'b1;
        end else begin
          cq.push_back({mvalid[ci], model[ci]});
          c_last = {mvalid[ci], model[ci]};
        end
      end
      if (clr_cnt != 0) begin
        model[DEPTH - clr_cnt]  = FILL_W;
        mvalid[DEPTH - clr_cnt] = 1'b1;
        clr_cnt--;
      end
    end else begin
      c_last  = {1'b1, 32'h0};
      clr_cnt = CLR_EN ? DEPTH : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cwr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b1; bus.c_adr_i = adr;
    bus.c_dat_i = dat;  bus.c_sel_i = sel; bus.v_stb_i = 1'b0;
    tick();
    bus.c_stb_i = 1'b0;
  endtask

  task automatic crd(input logic [31:0] adr);
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b0; bus.c_adr_i = adr; bus.v_stb_i = 1'b0;
    tick();
    bus.c_stb_i = 1'b0;
  endtask

  task automatic vrd(input logic [31:0] adr);
    bus.v_stb_i = 1'b1; bus.v_adr_i = adr;
    tick();
    bus.v_stb_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    c_last = {1'b1, 32'h0};
    rst = 1'b1;
    bus.v_cyc_i = 1'b0; bus.v_stb_i = 1'b0; bus.v_adr_i = '0;
    bus.c_cyc_i = 1'b0; bus.c_stb_i = 1'b0; bus.c_we_i = 1'b0;
    bus.c_sel_i = '0;   bus.c_adr_i = '0;   bus.c_dat_i = '0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    bus.v_cyc_i = 1'b1; bus.c_cyc_i = 1'b1;
    chk("rst_v_dat", bus.v_dat_o, 32'h0);
    chk("rst_c_dat", bus.c_dat_o, 32'h0);

`ifdef TEXTMEM_CLEAR_EN
    // T6: CPU read held during the whole clear; one video read mid-clear.
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b0; bus.c_adr_i = 32'h40;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.v_stb_i = (i == 100); bus.v_adr_i = 32'h40;
      tick();
    end
    bus.v_stb_i = 1'b0; bus.c_stb_i = 1'b0;
    tick();
    chk("t6_mid_clear_v", bus.v_dat_o, 32'h0720_0720);
    chk("t6_clr_done", clr_cnt, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.v_stb_i = 1'b1; bus.v_adr_i = 32'(i) << 2;
      tick();
    end
    bus.v_stb_i = 1'b0;
    tick();
`endif

    // Prefill words 0..39 with back-to-back CPU writes.
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b1; bus.c_sel_i = 4'hf;
    for (int i = 0; i < 40; i++) begin
      bus.c_adr_i = 32'(i) << 2; bus.c_dat_i = 32'hA000_0000 | 32'(i);
      tick();
    end
    bus.c_stb_i = 1'b0;
    tick();

    // T1: write then video read of the same word.
    cwr(32'h10, 32'h1234_5678, 4'hf);
    vrd(32'h10);
    tick();
    chk("t1_v_dat", bus.v_dat_o, 32'h1234_5678);

    // T2: 40-read video burst with a CPU read stalled throughout.
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b0; bus.c_adr_i = 32'h14;
    for (int i = 0; i < 40; i++) begin
      bus.v_stb_i = 1'b1; bus.v_adr_i = 32'(i) << 2;
      tick();
    end
    bus.v_stb_i = 1'b0;
    tick();
    bus.c_stb_i = 1'b0;
    tick();
    chk("t2_c_dat", bus.c_dat_o, 32'hA000_0005);

    // T3: partial byte-select write merge.
    cwr(32'h20, 32'hAABB_CCDD, 4'hf);
    cwr(32'h20, 32'h1122_3344, 4'b0101);
    crd(32'h20);
    tick();
    chk("t3_merge", bus.c_dat_o, 32'hAA22_CC44);

    // T4: high address bits alias; low two bits ignored.
    cwr((32'h1 << (AW + 2)) | 32'h8, 32'hCAFE_F00D, 4'hf);
    vrd(32'hB);
    tick();
    chk("t4_alias", bus.v_dat_o, 32'hCAFE_F00D);

    // Same-word conflict: video wins and sees old data; CPU write lands next cycle.
    bus.v_stb_i = 1'b1; bus.v_adr_i = 32'h8;
    bus.c_stb_i = 1'b1; bus.c_we_i = 1'b1; bus.c_adr_i = 32'h8;
    bus.c_dat_i = 32'h55AA_55AA; bus.c_sel_i = 4'hf;
    tick();
    chk("conf_old", bus.v_dat_o, 32'hCAFE_F00D);
    bus.v_stb_i = 1'b0;
    tick();
    bus.c_stb_i = 1'b0;
    vrd(32'h8);
    tick();
    chk("conf_new", bus.v_dat_o, 32'h55AA_55AA);

    // T5: aborts on both ports.
    vrd(32'h0);
    bus.v_cyc_i = 1'b0;
    tick();
    bus.v_cyc_i = 1'b1;
    crd(32'h4);
    bus.c_cyc_i = 1'b0;
    tick();
    bus.c_cyc_i = 1'b1;
    tick();

    // T5: reset while a CPU read is in flight; committed write survives (unless cleared).
    cwr(32'h30, 32'h0BAD_CAFE, 4'hf);
    crd(32'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_rst_c_dat", bus.c_dat_o, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) if (clr_cnt != 0) tick();
    crd(32'h30);
    tick();
    chk("t5_kept", bus.c_dat_o, CLR_EN ? FILL_W : 32'h0BAD_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
